interval_timer: RTL

//   Bus-mapped programmable down-counting interval timer on the peripheral bus next to the

---
 rtl/interval_timer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/interval_timer.sv
// Bus-mapped down-counting interval timer on a shared 1 us timebase.
// Optional prescaler enabled by defining INTERVAL_TIMER_PRESCALE_EN.
module interval_timer #(
  parameter int CLK_FREQ = 12000000,
  parameter int TICK_HZ  = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  input  logic        we,
  input  logic        re,
  output logic        irq
);

  localparam int DIV_RAW = CLK_FREQ / TICK_HZ;
  localparam int DIV = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam logic [31:0] DIV_M1 = 32'(DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_next;
  logic        irq_en, auto_reload, pend;
  logic [31:0] load, count, tick_cnt;
  logic        run, tick, dec_tick, expire, start;
  logic        wr_ctrl, wr_load, wr_count, wr_status;
  logic        unused_re;

  assign unused_re = re;

  assign wr_ctrl   = we && (address == 8'h00);
  assign wr_load   = we && (address == 8'h04);
  assign wr_count  = we && (address == 8'h08);
  assign wr_status = we && (address == 8'h0C);

  assign run    = (state == RUN);
  assign start  = wr_ctrl && write_data[0] && !run;
  assign tick   = run && (tick_cnt == DIV_M1);
  assign expire = dec_tick && (count == 32'd0);
  assign irq    = pend && irq_en;

`ifdef INTERVAL_TIMER_PRESCALE_EN
  logic [15:0] prescale, ps_cnt;
  logic        wr_ps;

  assign wr_ps    = we && (address == 8'h10);
  // >= so a PRESCALE lowered below the running count still wraps
  assign dec_tick = tick && (ps_cnt >= prescale);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale <= '0;
      ps_cnt   <= '0;
    end else begin
      if (start)
        ps_cnt <= '0;
      else if (tick)
        ps_cnt <= dec_tick ? 16'd0 : ps_cnt + 16'd1;
      if (wr_ps)
        prescale <= write_data[15:0];
    end
  end
`else
  assign dec_tick = tick;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (wr_ctrl)
      state_next = write_data[0] ? RUN : IDLE;
    else if (expire && !auto_reload)
      state_next = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en      <= 1'b0;
      auto_reload <= 1'b0;
      pend        <= 1'b0;
      load        <= '0;
      count       <= '0;
      tick_cnt    <= '0;
    end else begin
      if (wr_ctrl) begin
        irq_en      <= write_data[2];
        auto_reload <= write_data[1];
      end
      if (wr_load)
        load <= write_data;
      if (start)
        tick_cnt <= '0;
      else if (run)
        tick_cnt <= tick ? 32'd0 : tick_cnt + 32'd1;
      // bus writes take priority over the timer's own update
      if (start)
        count <= load;
      else if (wr_count)
        count <= write_data;
      else if (expire && auto_reload)
        count <= load;
      else if (dec_tick && count != 32'd0)
        count <= count - 32'd1;
      if (expire)
        pend <= 1'b1;
      else if (wr_status && write_data[0])
        pend <= 1'b0;
    end
  end

  always_comb begin
    read_data = '0;
    case (address)
      8'h00: read_data = {29'd0, irq_en, auto_reload, run};
      8'h04: read_data = load;
      8'h08: read_data = count;
      8'h0C: read_data = {30'd0, run, pend};
`ifdef INTERVAL_TIMER_PRESCALE_EN
      8'h10: read_data = {16'd0, prescale};
`endif
      default: read_data = '0;
    endcase
  end

endmodule
